// File: rtl/aes_result_display.sv
// Display stage for AES results: steps through the 16 bytes of a captured word,
// converts each byte to decimal by double-dabble and drives three active-low 7-segment digits.
module aes_result_display #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         stop,
  input  logic [127:0] data_in,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX2,
  output logic [3:0]   LEDR,
  output logic         busy,
  output logic         disp_valid
);

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [6:0]       SEG_BLANK  = 7'b1111111;

  state_t           state_reg, state_next;
  logic [127:0]     data_reg;
  logic [3:0]       byte_idx_reg;
  logic [19:0]      shift_reg;
  logic [19:0]      shift_adj;
  logic [19:0]      shift_step;
  logic [2:0]       shift_cnt_reg;
  logic [CNT_W-1:0] dwell_cnt_reg;
  logic [3:0]       byte_idx_next;
  logic [7:0]       next_byte;
  logic             last_shift;
  logic             dwell_done;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction on each BCD nibble before the shift.
  assign shift_adj[7:0] = shift_reg[7:0];
  for (genvar gi = 0; gi < 3; gi++) begin : g_add3
    assign shift_adj[8+4*gi +: 4] = (shift_reg[8+4*gi +: 4] >= 4'd5) ?
                                    shift_reg[8+4*gi +: 4] + 4'd3 :
                                    shift_reg[8+4*gi +: 4];
  end
  assign shift_step = {shift_adj[18:0], 1'b0};

  assign last_shift    = (shift_cnt_reg == 3'd7);
  assign dwell_done    = (dwell_cnt_reg == DWELL_LAST);
  assign byte_idx_next = byte_idx_reg + 4'd1;
  assign next_byte     = data_reg[{byte_idx_next, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (stop) begin
      state_next = IDLE;
    end else if (load) begin
      state_next = CONVERT;
    end else begin
      case (state_reg)
        CONVERT: if (last_shift) state_next = SHOW;
        SHOW:    if (dwell_done) state_next = CONVERT;
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    busy = (state_reg == CONVERT) || (state_reg == SHOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg      <= '0;
      byte_idx_reg  <= '0;
      shift_reg     <= '0;
      shift_cnt_reg <= '0;
      dwell_cnt_reg <= '0;
      HEX0          <= SEG_BLANK;
      HEX1          <= SEG_BLANK;
      HEX2          <= SEG_BLANK;
      LEDR          <= '0;
      disp_valid    <= 1'b0;
    end else if (stop) begin
      HEX0       <= SEG_BLANK;
      HEX1       <= SEG_BLANK;
      HEX2       <= SEG_BLANK;
      disp_valid <= 1'b0;
    end else if (load) begin
      data_reg      <= data_in;
      byte_idx_reg  <= '0;
      shift_reg     <= {12'd0, data_in[7:0]};
      shift_cnt_reg <= '0;
    end else begin
      case (state_reg)
        CONVERT: begin
          shift_reg     <= shift_step;
          shift_cnt_reg <= shift_cnt_reg + 3'd1;
          if (last_shift) begin
            // The display is fed from the final shifted value, not the registered one.
            HEX0          <= seg(shift_step[11:8]);
            HEX1          <= seg(shift_step[15:12]);
            HEX2          <= seg(shift_step[19:16]);
            LEDR          <= byte_idx_reg;
            disp_valid    <= 1'b1;
            dwell_cnt_reg <= '0;
          end
        end
        SHOW: begin
          if (dwell_done) begin
            byte_idx_reg  <= byte_idx_next;
            shift_reg     <= {12'd0, next_byte};
            shift_cnt_reg <= '0;
            dwell_cnt_reg <= '0;
          end else begin
            dwell_cnt_reg <= dwell_cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_result_display.sv
// Bench for aes_result_display: fixed vectors, hand-written corner sequences and a
// randomized run checked every cycle against a timing/arithmetic model.
module tb_aes_result_display;

  localparam int D = 4;
  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};
  localparam logic [20:0] BLANK3 = {3{7'b1111111}};

  logic         clk = 1'b0;
  logic         rst, load, stop;
  logic [127:0] data_in;
  logic [6:0]   HEX0, HEX1, HEX2;
  logic [3:0]   LEDR;
  logic         busy, disp_valid;

  int n_checks = 0;
  int n_fail   = 0;

  aes_result_display #(.DWELL_CYCLES(D), .CNT_W(26)) dut (
    .clk(clk), .rst(rst), .load(load), .stop(stop), .data_in(data_in),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .LEDR(LEDR),
    .busy(busy), .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    int           wait_cyc;
    logic [20:0]  hex;
    logic [3:0]   led;
  } vec_t;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] disp_of(input logic [7:0] v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    return {SEG[h], SEG[t], SEG[u]};
  endfunction

  task automatic check_idle(input string name);
    check({name, "_hex"}, {HEX2, HEX1, HEX0}, BLANK3);
    check({name, "_busy_valid"}, {busy, disp_valid}, 2'b00);
  endtask

  localparam logic [127:0] AES = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] EXT = 128'hff_0101_0101_0101_0101_0101_0101_0101_00;
  localparam logic [127:0] DA  = 128'hc8 << 40;
  localparam logic [127:0] DB  = (128'hab << 8) | 128'h07;

  vec_t vecs [6];

  // Model state for the randomized phase.
  bit          m_active;
  int          m_t0, cyc;
  logic [127:0] m_data;
  logic [20:0] m_hex, snap_hex;
  logic [3:0]  m_led, snap_led;
  bit          m_valid, snap_valid;

  initial begin
    rst = 1'b1; load = 1'b0; stop = 1'b0; data_in = '0;

    vecs[0] = '{AES,   8, {7'b1000000, 7'b0010000, 7'b1000000}, 4'd0};
    vecs[1] = '{AES,  20, {7'b1111001, 7'b0010000, 7'b1111000}, 4'd1};
    vecs[2] = '{AES,  32, {7'b1111001, 7'b0000000, 7'b1000000}, 4'd2};
    vecs[3] = '{AES, 188, {7'b1111001, 7'b1000000, 7'b0010010}, 4'd15};
    vecs[4] = '{EXT, 188, {7'b0100100, 7'b0010010, 7'b0010010}, 4'd15};
    vecs[5] = '{EXT, 200, {7'b1000000, 7'b1000000, 7'b1000000}, 4'd0};

    // Reset for two cycles, then idle with load low.
    tick; tick;
    check_idle("reset");
    check("reset_ledr", LEDR, 4'd0);
    rst = 1'b0;
    tick; tick;
    check_idle("idle_hold");
    check("idle_ledr", LEDR, 4'd0);
    $display("reset sequence done");

    // Fixed vectors: each one restarts with a fresh load.
    for (int i = 0; i < 6; i++) begin
      data_in = vecs[i].data; load = 1'b1;
      tick;
      load = 1'b0;
      repeat (vecs[i].wait_cyc) tick;
      check($sformatf("vec%0d_hex", i), {HEX2, HEX1, HEX0}, vecs[i].hex);
      check($sformatf("vec%0d_ledr", i), LEDR, vecs[i].led);
      check($sformatf("vec%0d_busy_valid", i), {busy, disp_valid}, 2'b11);
      $display("vec %0d: data=%h after %0d cycles ledr=%0d", i, vecs[i].data, vecs[i].wait_cyc, LEDR);
    end

    // Restart while byte 5 is in SHOW: old value holds 8 cycles, then 007.
    data_in = DA; load = 1'b1;
    tick;
    load = 1'b0;
    repeat (68) tick;
    check("restart_pre_hex", {HEX2, HEX1, HEX0}, disp_of(8'd200));
    check("restart_pre_ledr", LEDR, 4'd5);
    tick;
    data_in = DB; load = 1'b1;
    tick;
    load = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick;
      check($sformatf("restart_hold%0d", i), {HEX2, HEX1, HEX0, LEDR, busy, disp_valid},
            {disp_of(8'd200), 4'd5, 2'b11});
    end
    tick;
    check("restart_new", {HEX2, HEX1, HEX0, LEDR, disp_valid},
          {7'b1000000, 7'b1000000, 7'b1111000, 4'd0, 1'b1});
    $display("restart sequence done");

    // stop together with load during CONVERT: stop wins, data_reg untouched.
    data_in = DA; load = 1'b1;
    tick;
    load = 1'b0;
    repeat (3) tick;
    data_in = DB; load = 1'b1; stop = 1'b1;
    tick;
    load = 1'b0; stop = 1'b0;
    check_idle("stop_load");
    check("stop_data_reg", dut.data_reg, DA);
    $display("stop/load collision done");

    // Reset on the 4th shift cycle, then no update without a new load.
    data_in = AES; load = 1'b1;
    tick;
    load = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    check_idle("rst_mid");
    check("rst_mid_ledr", LEDR, 4'd0);
    check("rst_mid_data_reg", dut.data_reg, 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      check($sformatf("rst_after%0d", i), {HEX2, HEX1, HEX0, LEDR, busy, disp_valid},
            {BLANK3, 4'd0, 2'b00});
    end
    $display("reset mid-convert done");

    // Randomized phase against the model.
    rst = 1'b1; tick; tick; rst = 1'b0;
    m_active = 0; m_t0 = 0; cyc = 0; m_data = '0;
    m_hex = BLANK3; m_led = 4'd0; m_valid = 0;
    snap_hex = BLANK3; snap_led = 4'd0; snap_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      bit l, s;
      logic [127:0] d;
      l = (i == 0) || ($urandom_range(0, 99) == 0);
      s = (i != 0) && ($urandom_range(0, 249) == 0);
      d = {$urandom, $urandom, $urandom, $urandom};
      load = l; stop = s; data_in = d;
      tick;
      cyc++;
      if (s) begin
        m_active = 0; m_hex = BLANK3; m_valid = 0;
      end else if (l) begin
        snap_hex = m_hex; snap_led = m_led; snap_valid = m_valid;
        m_active = 1; m_t0 = cyc; m_data = d;
        $display("random load at cycle %0d data=%h", cyc, d);
      end
      if (!s && m_active) begin
        int e, idx;
        e = cyc - m_t0;
        if (e < 8) begin
          m_hex = snap_hex; m_led = snap_led; m_valid = snap_valid;
        end else begin
          idx = ((e - 8) / (D + 8)) % 16;
          m_hex = disp_of(m_data[8*idx +: 8]);
          m_led = idx[3:0];
          m_valid = 1;
        end
      end
      check($sformatf("rand_c%0d", cyc), {HEX2, HEX1, HEX0, LEDR, busy, disp_valid},
            {m_hex, m_led, m_active, m_valid});
    end
    load = 1'b0; stop = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
